// File: rtl/sfp_mdio_responder.sv
// Clause 45 MDIO responder: MDC/MDIO are oversampled in wb_clk_i, frames are decoded on
// detected MDC rising edges and mapped onto a single-address local register port.
module sfp_mdio_responder #(
    parameter int unsigned PRE_MIN    = 32,
    parameter logic [31:0] DEVAD_MASK = 32'h0000_0002,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [4:0]  prtad,
    input  logic        mdc_i,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic [4:0]  reg_devad,
    output logic [15:0] reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_wr,
    output logic        reg_rd,
    input  logic [15:0] reg_rdata,
    output logic        busy
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_PRE, S_HDR, S_TA, S_WDATA, S_RDATA} state_t;

    // MDIO goes through the same depth as MDC so the sampled bit lines up with rise_q.
    logic [2:0] mdc_q;
    logic [1:0] mdio_q;
    logic       rise_q;
    logic       bit_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            mdc_q  <= '0;
            mdio_q <= '1;
            rise_q <= 1'b0;
            bit_q  <= 1'b1;
        end else begin
            mdc_q  <= {mdc_q[1:0], mdc_i};
            mdio_q <= {mdio_q[0], mdio_i};
            rise_q <= mdc_q[1] & ~mdc_q[2];
            bit_q  <= mdio_q[1];
        end
    end

    state_t          state_q;
    logic [5:0]      pre_cnt_q, bit_cnt_q;
    logic [15:0]     sr_q, rd_sr_q;
    logic [1:0]      op_q;
    logic [4:0]      devad_q;
    logic            match_q;
    logic [TW-1:0]   tmo_q;
    logic            mdio_o_q, mdio_oe_q, reg_wr_q, reg_rd_q, busy_q;
    logic [4:0]      reg_devad_q;
    logic [15:0]     reg_addr_q, reg_wdata_q;

    logic [15:0] shift_d;
    logic [5:0]  bit_d;
    logic        hdr_ok;

    // shift_d[13:0] holds frame bits 1..14 when bit 14 is sampled; bits 17..32 at bit 32.
    assign shift_d = {sr_q[14:0], bit_q};
    assign bit_d   = bit_cnt_q + 6'd1;
    assign hdr_ok  = !shift_d[12] && (shift_d[9:5] == prtad) && DEVAD_MASK[shift_d[4:0]];

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= S_PRE;
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            rd_sr_q     <= '0;
            op_q        <= '0;
            devad_q     <= '0;
            match_q     <= 1'b0;
            tmo_q       <= '0;
            mdio_o_q    <= 1'b1;
            mdio_oe_q   <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
            reg_devad_q <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
        end else begin
            reg_wr_q <= 1'b0;
            reg_rd_q <= 1'b0;
            if (state_q != S_PRE && !rise_q) begin
                if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_q   <= S_PRE;
                    pre_cnt_q <= '0;
                    tmo_q     <= '0;
                    mdio_oe_q <= 1'b0;
                    mdio_o_q  <= 1'b1;
                    busy_q    <= 1'b0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else if (rise_q) begin
                tmo_q <= '0;
                if (state_q != S_PRE) begin
                    bit_cnt_q <= bit_d;
                    sr_q      <= shift_d;
                end
                case (state_q)
                    S_PRE: begin
                        if (bit_q) begin
                            if (pre_cnt_q != 6'd32) pre_cnt_q <= pre_cnt_q + 6'd1;
                        end else if (pre_cnt_q >= 6'(PRE_MIN)) begin
                            state_q   <= S_HDR;
                            bit_cnt_q <= 6'd1;
                            sr_q      <= '0;
                            busy_q    <= 1'b1;
                            pre_cnt_q <= '0;
                        end else begin
                            pre_cnt_q <= '0;
                        end
                    end
                    S_HDR: begin
                        if (bit_d == 6'd14) begin
                            state_q <= S_TA;
                            op_q    <= shift_d[11:10];
                            devad_q <= shift_d[4:0];
                            match_q <= hdr_ok;
                            if (hdr_ok && shift_d[11]) begin
                                reg_rd_q    <= 1'b1;
                                reg_devad_q <= shift_d[4:0];
                            end
                        end
                    end
                    S_TA: begin
                        if (bit_d == 6'd15) begin
                            if (match_q && op_q[1]) begin
                                rd_sr_q   <= reg_rdata;
                                mdio_oe_q <= 1'b1;
                                mdio_o_q  <= 1'b0;
                            end
                        end else begin
                            // Foreign frames ride through WDATA purely to count out to bit 32.
                            state_q <= (match_q && op_q[1]) ? S_RDATA : S_WDATA;
                            if (match_q && op_q[1]) begin
                                mdio_o_q <= rd_sr_q[15];
                                rd_sr_q  <= {rd_sr_q[14:0], 1'b0};
                            end
                        end
                    end
                    S_RDATA: begin
                        if (bit_d == 6'd32) begin
                            state_q   <= S_PRE;
                            pre_cnt_q <= '0;
                            busy_q    <= 1'b0;
                            mdio_oe_q <= 1'b0;
                            mdio_o_q  <= 1'b1;
                            if (op_q == 2'b10) reg_addr_q <= reg_addr_q + 16'd1;
                        end else begin
                            mdio_o_q <= rd_sr_q[15];
                            rd_sr_q  <= {rd_sr_q[14:0], 1'b0};
                        end
                    end
                    S_WDATA: begin
                        if (bit_d == 6'd32) begin
                            state_q   <= S_PRE;
                            pre_cnt_q <= '0;
                            busy_q    <= 1'b0;
                            if (match_q && op_q == 2'b00) begin
                                reg_addr_q  <= shift_d;
                                reg_devad_q <= devad_q;
                            end
                            if (match_q && op_q == 2'b01) begin
                                reg_wdata_q <= shift_d;
                                reg_wr_q    <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= S_PRE;
                endcase
            end
        end
    end

    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = mdio_oe_q;
    assign reg_devad = reg_devad_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_wr    = reg_wr_q;
    assign reg_rd    = reg_rd_q;
    assign busy      = busy_q;
endmodule

// File: doc/sfp_mdio_responder.md
# sfp_mdio_responder

Clause 45 MDIO responder (the PHY/MMD end of the 10GbE management bus) that decodes station frames on MDC/MDIO and maps them onto a simple local register port. It sits behind the SFP mezzanine MDIO pins in loopback/emulation builds and serves as the bench model for the SFP MDIO master path. MDC and MDIO are oversampled in the system clock domain; the MDIO output is open-drain style (data plus output enable).

## Interface
- PRE_MIN, 32: consecutive preamble ones required before a start is accepted (1..32)
- DEVAD_MASK, 32'h0000_0002: bit n set means MMD n is implemented; all other DEVADs are ignored
- TIMEOUT, 4096: wb_clk_i cycles without an MDC rising edge mid-frame before abort
- wb_clk_i  in  1  system clock; must be at least 8x the MDC frequency
- wb_rst_n_i  in  1  asynchronous, active-low reset
- prtad  in  5  port address this responder answers to (quasi-static)
- mdc_i  in  1  MDC pin, asynchronous
- mdio_i  in  1  MDIO pin input, asynchronous
- mdio_o  out  1  MDIO drive value
- mdio_oe  out  1  MDIO drive enable (1 = drive mdio_o)
- reg_devad  out  5  DEVAD of the current access
- reg_addr  out  16  current register address
- reg_wdata  out  16  write data, valid with reg_wr
- reg_wr  out  1  one-cycle write strobe
- reg_rd  out  1  one-cycle read request
- reg_rdata  in  16  read data; valid no later than 2 cycles after reg_rd and held until the frame ends
- busy  out  1  high from accepted ST through frame end

## Operation
- mdc_i and mdio_i pass through 2-FF synchronizers; rising MDC edge detected from sync stages. All frame sampling happens on detected rising edges.
- States: PRE, HDR, TA, WDATA, RDATA.
- PRE: count sampled ones, saturating at 32; a sampled 0 with count >= PRE_MIN enters HDR (first ST bit consumed); a 0 with count < PRE_MIN clears count.
- HDR: shift 13 further bits: ST[0], OP[1:0], PRTAD[4:0], DEVAD[4:0]. ST must be 00; ST=01 (Clause 22) or PRTAD != prtad or DEVAD_MASK[DEVAD]=0 -> frame is "foreign": continue counting bits to 32 without driving or strobing, then PRE.
- OP 00 address, 01 write, 11 read, 10 post-read-increment-address.
- On the edge sampling the last DEVAD bit of a matching read/read-inc frame: reg_rd pulses, reg_devad updated.
- TA: for read ops, after the edge sampling TA bit 1, mdio_oe=1, mdio_o=0; write/address ops ignore TA values.
- RDATA: reg_rdata latched on edge sampling TA bit 1; after each subsequent rising edge drive next bit MSB first (D15 after TA2 edge ... D0 after edge 31). After the edge sampling D0 (bit 32), mdio_oe=0, mdio_o=1.
- WDATA: shift 16 bits MSB first. After bit 32: OP 00 -> reg_addr <= data, reg_devad <= DEVAD; OP 01 -> reg_wdata <= data, reg_wr pulses with current reg_addr.
- Read-inc: after bit 32, reg_addr <= reg_addr+1, 16-bit wrap 16'hFFFF -> 16'h0000. Plain read and write do not increment.
- Single shared address register (not per-MMD).
- Frame end (bit 32) always returns to PRE with count 0.

## Timing
- Reset values: mdio_o=1, mdio_oe=0, reg_wr=0, reg_rd=0, reg_addr=0, reg_devad=0, reg_wdata=0, busy=0, state PRE, count 0.
- Pin edge to detected edge: 3 wb_clk_i cycles; mdio_o/mdio_oe update 1 cycle after detection (4 cycles from pin MDC rise), well inside the 300 ns Clause 45 output window at supported ratios.
- reg_wr asserted 1 cycle after detection of bit-32 edge, exactly one cycle wide; reg_rd likewise one cycle wide.
- Timeout: counter reset on every detected MDC rise while state != PRE; reaching TIMEOUT forces PRE, mdio_oe=0, no strobes, busy=0.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronous); no strobe completes.
- MDIO changes coinciding with an MDC edge: value from the same synchronizer depth is used (both 2 FF), no extra skew compensation.

## Test plan
- Address then write: 32 ones, ST 00 OP 00 PRTAD=prtad DEVAD 1 addr 16'h0020, then write frame data 16'hBEEF -> reg_addr=16'h0020, one reg_wr pulse with reg_wdata=16'hBEEF, reg_devad=1.
- Read: reg_rdata=16'hA5C3 -> reg_rd pulse after DEVAD, mdio_oe high for 17 bit times, TA2=0, serial 1010010111000011, oe low after bit 32.
- Read-inc at addr 16'hFFFF twice -> reg_addr 16'h0000 then 16'h0001; plain read leaves address unchanged.
- Foreign frames: wrong PRTAD, DEVAD 3 (masked), ST=01 -> mdio_oe never asserted, no reg_wr/reg_rd, next valid frame accepted.
- Short preamble (PRE_MIN=32, 31 ones) -> frame ignored; PRE_MIN=1 with 1 one -> accepted.
- MDC stops after bit 20 of a read -> after TIMEOUT cycles mdio_oe=0, busy=0; async reset mid-write -> no reg_wr, all outputs at reset values.
